// File: rtl/seg_display_pkg.sv
// rtl/seg_display_pkg.sv - glyph table and per-digit register type for the scan controller
package seg_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low gfedcba glyphs; element 0 is the rightmost entry.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic [3:0] val;
    logic [6:0] raw;
    logic       raw_sel;
    logic       enable;
    logic       blink;
    logic       dp;
  } digit_cfg_t;

endpackage

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - hex nibble to active-low seven-segment glyph
module seg_hex_decode
  import seg_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_GLYPH[nibble_i];

endmodule

// File: rtl/seg_display_scan.sv
// rtl/seg_display_scan.sv - multiplexed seven-segment scan with frame-synchronous glyph updates
module seg_display_scan
  import seg_display_pkg::*;
#(
  parameter int N_DIGITS  = 8,
  parameter int PRESCALE  = 1024,
  parameter int BLINK_DIV = 64,
  parameter int DIM_BITS  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digit_val,
  input  logic [7*N_DIGITS-1:0] raw_seg,
  input  logic [N_DIGITS-1:0]   raw_sel,
  input  logic [N_DIGITS-1:0]   enable,
  input  logic [N_DIGITS-1:0]   blink,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [DIM_BITS-1:0]   brightness,
  output logic [N_DIGITS-1:0]   anodes,
  output logic [6:0]            segs,
  output logic                  dp_n,
  output logic                  frame_tick
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int ON_W  = CNT_W + DIM_BITS + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BLK_W-1:0] bcnt_q, bcnt_d;
  logic             phase_q, phase_d;

  digit_cfg_t [N_DIGITS-1:0] live_cfg, pend_q, pend_d, act_q, act_d;
  logic [DIM_BITS-1:0]       pend_bright_q, pend_bright_d, act_bright_q, act_bright_d;

  logic [N_DIGITS-1:0] anodes_q, anodes_d;
  logic [6:0]          segs_q, segs_d;
  logic                dp_n_q, dp_n_d;
  logic                tick_q;

  logic             slot_end, frame_end, lit;
  logic [ON_W-1:0]  on_prod;
  logic [CNT_W-1:0] on_time;
  digit_cfg_t       cur;
  logic [6:0]       hex_seg;

  always_comb begin
    for (int i = 0; i < N_DIGITS; i++) begin
      live_cfg[i] = '{val: digit_val[4*i +: 4], raw: raw_seg[7*i +: 7], raw_sel: raw_sel[i],
                      enable: enable[i], blink: blink[i], dp: dp[i]};
    end
  end

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (idx_q == IDX_LAST);

  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) idx_d = frame_end ? '0 : idx_q + 1'b1;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (frame_end) begin
      if (bcnt_q == BLK_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
    pend_d        = load ? live_cfg : pend_q;
    pend_bright_d = load ? brightness : pend_bright_q;
    // A load coinciding with the frame end bypasses pending so it shows next frame.
    act_d        = act_q;
    act_bright_d = act_bright_q;
    if (frame_end) begin
      act_d        = load ? live_cfg : pend_q;
      act_bright_d = load ? brightness : pend_bright_q;
    end
  end

  assign on_prod = (ON_W'(act_bright_q) + ON_W'(1)) * ON_W'(CNT_LAST);
  assign on_time = CNT_W'(on_prod >> DIM_BITS);

  assign cur = act_q[idx_q];

  seg_hex_decode u_hex (
    .nibble_i (cur.val),
    .seg_o    (hex_seg)
  );

  // cnt == 0 stays dark so the previous digit's segments never ghost onto the next anode.
  assign lit = (cnt_q != '0) && (cnt_q <= on_time) && cur.enable && !(cur.blink && phase_q);

  assign anodes_d = lit ? ~(N_DIGITS'(1) << idx_q) : '1;
  assign segs_d   = lit ? (cur.raw_sel ? cur.raw : hex_seg) : SEG_BLANK;
  assign dp_n_d   = ~(lit && cur.dp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      bcnt_q        <= '0;
      phase_q       <= 1'b0;
      pend_q        <= '0;
      pend_bright_q <= '0;
      act_q         <= '0;
      act_bright_q  <= '0;
      anodes_q      <= '1;
      segs_q        <= SEG_BLANK;
      dp_n_q        <= 1'b1;
      tick_q        <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      bcnt_q        <= bcnt_d;
      phase_q       <= phase_d;
      pend_q        <= pend_d;
      pend_bright_q <= pend_bright_d;
      act_q         <= act_d;
      act_bright_q  <= act_bright_d;
      anodes_q      <= anodes_d;
      segs_q        <= segs_d;
      dp_n_q        <= dp_n_d;
      tick_q        <= frame_end;
    end
  end

  assign anodes     = anodes_q;
  assign segs       = segs_q;
  assign dp_n       = dp_n_q;
  assign frame_tick = tick_q;

endmodule
